// File: rtl/csr_regfile_pkg.sv
// csr_regfile_pkg: CSR numbers, field positions, exception codes and the masked-write helper
package csr_regfile_pkg;
  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0c;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;
  localparam int CRMD_IE    = 2;
  localparam int ECFG_RSVD  = 10;
  localparam int IS_TI      = 11;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  function automatic logic [31:0] csr_mask_wr(input logic [31:0] old, input logic [31:0] mask,
                                              input logic [31:0] val);
    return (old & ~mask) | (val & mask);
  endfunction
endpackage

// File: rtl/csr_timer.sv
// csr_timer: TCFG/TVAL countdown with one-shot or periodic reload; tick marks TVAL reaching 0 while enabled
module csr_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wv,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        tick
);
  assign tick = tcfg[0] && tval == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg <= '0;
      tval <= '1;
    end else if (tcfg_we) begin
      tcfg <= tcfg_wv;
      tval <= {tcfg_wv[31:2], 2'b00};
    end else if (tcfg[0] && tval != '1) begin
      tval <= (tval == '0 && tcfg[1]) ? {tcfg[31:2], 2'b00} : tval - 32'd1;
    end
  end
endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: CSR storage, exception/ERTN commit, interrupt pending and CSR read port.
// Timer CSRs (TCFG/TVAL/TICLR) and the timer interrupt exist only when CSR_TIMER_EN is defined.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] TID_INIT = 32'h0,
  parameter int          LIE_W    = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_rd_num,
  output logic [31:0] csr_rd_val,
  input  logic        csr_we,
  input  logic [13:0] csr_wr_num,
  input  logic [31:0] csr_wr_mask,
  input  logic [31:0] csr_wr_val,
  input  logic        ex_valid,
  input  logic [5:0]  ex_ecode,
  input  logic [8:0]  ex_esubcode,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry
);
  logic [3:0]       crmd;
  logic [2:0]       prmd;
  logic [LIE_W-1:0] lie, is_r;
  logic [5:0]       ecode;
  logic [8:0]       esubcode;
  logic [31:0]      era, badv, tid, wr_old, wv;
  logic [25:0]      eentry;
  logic [3:0][31:0] save;
  logic [13:0]      wsel;
  logic [1:0]       sw_next;
  logic             ti_next;
`ifdef CSR_TIMER_EN
  logic [31:0]      tcfg, tval;
  logic             tick;
`endif
  function automatic logic [31:0] rd(input logic [13:0] n);
    case (n)
      CSR_CRMD:   return {28'b0, crmd};
      CSR_PRMD:   return {29'b0, prmd};
      CSR_ECFG:   return {{(32-LIE_W){1'b0}}, lie};
      CSR_ESTAT:  return {1'b0, esubcode, ecode, {(16-LIE_W){1'b0}}, is_r};
      CSR_ERA:    return era;
      CSR_BADV:   return badv;
      CSR_EENTRY: return {eentry, 6'b0};
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: return save[n[1:0]];
      CSR_TID:    return tid;
`ifdef CSR_TIMER_EN
      CSR_TCFG:   return tcfg;
      CSR_TVAL:   return tval;
`endif
      default:    return '0;
    endcase
  endfunction
  assign csr_rd_val = rd(csr_rd_num);
  assign wr_old     = rd(csr_wr_num);
  assign wv         = csr_mask_wr(wr_old, csr_wr_mask, csr_wr_val);
  // A write colliding with an exception commit is dropped; all-ones selects no CSR.
  assign wsel       = (csr_we && !ex_valid) ? csr_wr_num : '1;
  assign sw_next    = wsel == CSR_ESTAT ? wv[1:0] : is_r[1:0];
  assign has_int    = |(is_r & lie) && crmd[CRMD_IE];
  assign ex_entry   = {eentry, 6'b0};
  assign ertn_entry = era;
`ifdef CSR_TIMER_EN
  csr_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .tcfg_we (wsel == CSR_TCFG),
    .tcfg_wv (wv),
    .tcfg    (tcfg),
    .tval    (tval),
    .tick    (tick)
  );
  assign ti_next = tick || (is_r[IS_TI] && !(wsel == CSR_TICLR && wv[0]));
`else
  assign ti_next = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd     <= 4'h8;
      prmd     <= '0;
      lie      <= '0;
      is_r     <= '0;
      ecode    <= '0;
      esubcode <= '0;
      era      <= '0;
      badv     <= '0;
      eentry   <= '0;
      save     <= '0;
      tid      <= TID_INIT;
    end else begin
      is_r <= {ipi_int_in, ti_next, 1'b0, hw_int_in, sw_next};
      if (ex_valid) begin
        prmd      <= crmd[2:0];
        crmd[2:0] <= 3'b000;
        era       <= ex_pc;
        ecode     <= ex_ecode;
        esubcode  <= ex_esubcode;
        badv      <= ex_ecode == ECODE_ADE ? ex_pc : ex_ecode == ECODE_ALE ? ex_vaddr : badv;
      end else begin
        crmd[2:0] <= ertn_flush ? prmd : wsel == CSR_CRMD ? wv[2:0] : crmd[2:0];
        if (wsel == CSR_CRMD) crmd[3] <= wv[3];
        if (wsel == CSR_PRMD) prmd <= wv[2:0];
        if (wsel == CSR_ERA) era <= wv;
      end
      if (wsel == CSR_ECFG) lie <= wv[LIE_W-1:0] & ~(LIE_W'(1) << ECFG_RSVD);
      if (wsel == CSR_EENTRY) eentry <= wv[31:6];
      if (wsel[13:2] == CSR_SAVE0[13:2]) save[wsel[1:0]] <= wv;
      if (wsel == CSR_TID) tid <= wv;
    end
  end
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed test-plan checks plus randomized traffic against a word-level CSR model
module tb_csr_regfile;
  localparam logic [31:0] TID0 = 32'h5A5A_0001;
  logic        clk = 1'b0, reset = 1'b1;
  logic [13:0] csr_rd_num = '0, csr_wr_num = '0;
  logic [31:0] csr_rd_val, csr_wr_mask = '0, csr_wr_val = '0;
  logic        csr_we = 1'b0, ex_valid = 1'b0, ertn_flush = 1'b0, ipi_int_in = 1'b0, has_int;
  logic [5:0]  ex_ecode = '0;
  logic [8:0]  ex_esubcode = '0;
  logic [31:0] ex_pc = '0, ex_vaddr = '0, ex_entry, ertn_entry;
  logic [7:0]  hw_int_in = '0;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] mr [0:127];
  bit          mvalid = 1'b0;

  csr_regfile #(.TID_INIT(TID0)) dut (
    .clk(clk), .reset(reset), .csr_rd_num(csr_rd_num), .csr_rd_val(csr_rd_val),
    .csr_we(csr_we), .csr_wr_num(csr_wr_num), .csr_wr_mask(csr_wr_mask), .csr_wr_val(csr_wr_val),
    .ex_valid(ex_valid), .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode), .ex_pc(ex_pc),
    .ex_vaddr(ex_vaddr), .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit impl(input logic [13:0] n);
    case (n)
      14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0c,
      14'h30, 14'h31, 14'h32, 14'h33, 14'h40: return 1'b1;
`ifdef CSR_TIMER_EN
      14'h41, 14'h42, 14'h44: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] wmask(input logic [13:0] n);
    case (n)
      14'h00: return 32'hf;
      14'h01: return 32'h7;
      14'h04: return 32'h1bff;
      14'h05: return 32'h3;
      14'h0c: return 32'hffff_ffc0;
      14'h06, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41: return '1;
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [13:0] n);
    return impl(n) ? mr[n[6:0]] : 32'h0;
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] o [0:127];
    logic [31:0] k, t;
    logic [6:0]  w;
    logic        ev, clr, tw;
    if (reset) begin
      foreach (mr[i]) mr[i] = '0;
      mr[0] = 32'h8;
      mr['h40] = TID0;
`ifdef CSR_TIMER_EN
      mr['h42] = '1;
`endif
      mvalid = 1'b1;
    end else begin
      o = mr;
      ev = 1'b0;
      clr = 1'b0;
      tw = 1'b0;
      w = csr_wr_num[6:0];
`ifdef CSR_TIMER_EN
      ev = o['h41][0] && o['h42] == 32'h0;
`endif
      if (csr_we && !ex_valid && impl(csr_wr_num)) begin
        k = csr_wr_mask & wmask(csr_wr_num);
        mr[w] = (o[w] & ~k) | (csr_wr_val & k);
        tw = csr_wr_num == 14'h41;
        clr = csr_wr_num == 14'h44 && csr_wr_val[0] && csr_wr_mask[0];
      end
      if (ertn_flush && !ex_valid) mr[0] = {mr[0][31:3], o[1][2:0]};
      if (ex_valid) begin
        mr[1] = {29'b0, o[0][2:0]};
        mr[0] = o[0] & ~32'h7;
        mr[6] = ex_pc;
        mr[5] = {1'b0, ex_esubcode, ex_ecode, o[5][15:0]};
        if (ex_ecode == 6'h08) mr[7] = ex_pc;
        else if (ex_ecode == 6'h09) mr[7] = ex_vaddr;
      end
`ifdef CSR_TIMER_EN
      if (tw) mr['h42] = {mr['h41][31:2], 2'b00};
      else if (o['h41][0] && o['h42] != 32'hffff_ffff)
        mr['h42] = (o['h42] == 32'h0 && o['h41][1]) ? {o['h41][31:2], 2'b00} : o['h42] - 32'd1;
`endif
      t = mr[5];
      t[9:2] = hw_int_in;
      t[10] = 1'b0;
      t[11] = ev || (o[5][11] && !clr);
      t[12] = ipi_int_in;
      mr[5] = t;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("rd_val", csr_rd_val, exp_rd(csr_rd_num));
      chk("has_int", {31'b0, has_int}, {31'b0, |(mr[5][12:0] & mr[4][12:0]) && mr[0][2]});
      chk("ex_entry", ex_entry, mr['h0c]);
      chk("ertn_entry", ertn_entry, mr[6]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
    csr_we = 1'b1;
    csr_wr_num = n;
    csr_wr_mask = m;
    csr_wr_val = v;
    step(1);
    csr_we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [13:0] n, input logic [31:0] exp);
    csr_rd_num = n;
    #1;
    chk(name, csr_rd_val, exp);
  endtask

  task automatic exc(input logic [5:0] ec, input logic [8:0] sub, input logic [31:0] pc,
                     input logic [31:0] va);
    ex_valid = 1'b1;
    ex_ecode = ec;
    ex_esubcode = sub;
    ex_pc = pc;
    ex_vaddr = va;
  endtask

  function automatic logic [13:0] pick();
    logic [13:0] t [16];
    t = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0c, 14'h30,
          14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h43};
    return $urandom_range(0, 7) == 0 ? 14'($urandom) : t[$urandom_range(0, 15)];
  endfunction

  initial begin
    step(2);
    reset = 1'b0;
    rd_chk("rst_crmd", 14'h00, 32'h8);
    rd_chk("rst_estat", 14'h05, 32'h0);
    rd_chk("rst_tid", 14'h40, TID0);
`ifdef CSR_TIMER_EN
    rd_chk("rst_tval", 14'h42, 32'hffff_ffff);
`else
    rd_chk("rst_tval", 14'h42, 32'h0);
`endif
    chk("rst_has_int", {31'b0, has_int}, 32'h0);
    wr(14'h00, 32'h7, 32'h7);
    rd_chk("crmd_wr", 14'h00, 32'hf);
    exc(6'h09, 9'h0, 32'h1C00_0100, 32'h0000_1003);
    step(1);
    ex_valid = 1'b0;
    rd_chk("ale_prmd", 14'h01, 32'h7);
    rd_chk("ale_crmd", 14'h00, 32'h8);
    rd_chk("ale_era", 14'h06, 32'h1C00_0100);
    rd_chk("ale_badv", 14'h07, 32'h0000_1003);
    rd_chk("ale_estat", 14'h05, 32'h0009_0000);
    chk("ale_ertn_entry", ertn_entry, 32'h1C00_0100);
    ertn_flush = 1'b1;
    step(1);
    ertn_flush = 1'b0;
    rd_chk("ertn_crmd", 14'h00, 32'hf);
`ifdef CSR_TIMER_EN
    wr(14'h41, '1, 32'h9);
    step(8);
    rd_chk("os_tval0", 14'h42, 32'h0);
    rd_chk("os_is_pre", 14'h05, 32'h0009_0000);
    step(1);
    rd_chk("os_is_set", 14'h05, 32'h0009_0800);
    rd_chk("os_tval_stop", 14'h42, 32'hffff_ffff);
    step(2);
    rd_chk("os_tval_hold", 14'h42, 32'hffff_ffff);
    wr(14'h44, '1, 32'h1);
    rd_chk("ticlr", 14'h05, 32'h0009_0000);
    wr(14'h04, '1, 32'h800);
    wr(14'h41, '1, 32'h7);
    step(4);
    rd_chk("per_tval0", 14'h42, 32'h0);
    chk("per_noint", {31'b0, has_int}, 32'h0);
    wr(14'h44, '1, 32'h1);
    chk("per_set_wins", {31'b0, has_int}, 32'h1);
    rd_chk("per_reload", 14'h42, 32'h4);
    wr(14'h44, '1, 32'h1);
    chk("per_cleared", {31'b0, has_int}, 32'h0);
    step(3);
    chk("per_gap", {31'b0, has_int}, 32'h0);
    step(1);
    chk("per_pulse2", {31'b0, has_int}, 32'h1);
    rd_chk("per_reload2", 14'h42, 32'h4);
    wr(14'h41, '1, 32'h0);
    wr(14'h44, '1, 32'h1);
`else
    wr(14'h41, '1, 32'h9);
    rd_chk("no_tcfg", 14'h41, 32'h0);
    step(10);
    rd_chk("no_tval", 14'h42, 32'h0);
    rd_chk("no_ti", 14'h05, 32'h0009_0000);
`endif
    exc(6'h08, 9'h1a3, 32'h1C00_0200, 32'hDEAD_0000);
    ertn_flush = 1'b1;
    csr_we = 1'b1;
    csr_wr_num = 14'h00;
    csr_wr_mask = '1;
    csr_wr_val = 32'h0;
    step(1);
    ex_valid = 1'b0;
    ertn_flush = 1'b0;
    csr_we = 1'b0;
    rd_chk("prio_crmd", 14'h00, 32'h8);
    rd_chk("prio_prmd", 14'h01, 32'h7);
    rd_chk("ade_badv", 14'h07, 32'h1C00_0200);
    rd_chk("ade_estat", 14'h05, 32'h68C8_0000);
    wr(14'h05, '1, '1);
    rd_chk("estat_mask", 14'h05, 32'h68C8_0003);
    wr(14'h04, '1, 32'h1fff);
    rd_chk("ecfg_rsvd", 14'h04, 32'h1bff);
    wr(14'h05, '1, 32'h0);
    wr(14'h00, 32'h4, 32'h4);
    chk("int_idle", {31'b0, has_int}, 32'h0);
    hw_int_in = 8'h10;
    #1;
    chk("int_latency", {31'b0, has_int}, 32'h0);
    step(1);
    chk("int_hw", {31'b0, has_int}, 32'h1);
    rd_chk("int_is", 14'h05, 32'h68C8_0040);
    hw_int_in = 8'h0;
    wr(14'h0c, '1, 32'h1C00_8ABC);
    chk("eentry", ex_entry, 32'h1C00_8A80);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 499) == 0;
      csr_rd_num = pick();
      csr_we = $urandom_range(0, 2) == 0;
      csr_wr_num = pick();
      csr_wr_mask = $urandom_range(0, 1) ? 32'hffff_ffff : $urandom;
      csr_wr_val = $urandom;
      if (csr_wr_num == 14'h41) begin
        csr_wr_mask = '1;
        csr_wr_val = ($urandom_range(0, 6) << 2) | $urandom_range(0, 3);
      end
      ex_valid = $urandom_range(0, 15) == 0;
      case ($urandom_range(0, 2))
        0: ex_ecode = 6'h08;
        1: ex_ecode = 6'h09;
        default: ex_ecode = 6'($urandom);
      endcase
      ex_esubcode = 9'($urandom);
      ex_pc = $urandom;
      ex_vaddr = $urandom;
      ertn_flush = $urandom_range(0, 11) == 0;
      hw_int_in = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h0;
      ipi_int_in = $urandom_range(0, 7) == 0;
      step(1);
    end
    reset = 1'b0;
    csr_we = 1'b0;
    ex_valid = 1'b0;
    ertn_flush = 1'b0;
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- CSR storage and exception-commit block. It is the consumer side of the mm2-stage exception/CSR-write controls.
- Takes the CSR write enable, ecode and esubcode qualified at commit. Updates CRMD/PRMD/ESTAT/ERA/BADV, provides CSR read data, and runs the timer.
- Drives the interrupt request back to the pipeline, plus the exception entry and ERTN return addresses used for the flush redirect.

Parameters:
- TID_INIT, 32'h0, reset value of TID.
- LIE_W, 13, width of the ECFG.LIE and ESTAT.IS interrupt fields.

Ports:
- clk  in  1  core clock; every state update on its rising edge.
- reset  in  1  synchronous, active-high reset.
- csr_rd_num  in  14  CSR number to read.
- csr_rd_val  out  32  read data; combinational from current registers.
- csr_we  in  1  commit-qualified CSR write (CSRWR/CSRXCHG).
- csr_wr_num  in  14  CSR number to write.
- csr_wr_mask  in  32  bit mask (all ones for CSRWR).
- csr_wr_val  in  32  write data.
- ex_valid  in  1  exception commits this cycle.
- ex_ecode  in  6  exception code.
- ex_esubcode  in  9  exception subcode.
- ex_pc  in  32  PC of the excepting instruction.
- ex_vaddr  in  32  faulting data address (ALE).
- ertn_flush  in  1  ERTN commits this cycle.
- hw_int_in  in  8  hardware interrupt lines.
- ipi_int_in  in  1  inter-processor interrupt.
- has_int  out  1  pending enabled interrupt.
- ex_entry  out  32  EENTRY value.
- ertn_entry  out  32  ERA value.

Behaviour:
- Implemented CSRs:
  - CRMD 0x0: PLV[1:0], IE[2], DA[3].
  - PRMD 0x1: PPLV[1:0], PIE[2].
  - ECFG 0x4: LIE[12:0]; bit 10 reads 0.
  - ESTAT 0x5: IS[12:0], Ecode[21:16], EsubCode[30:22].
  - ERA 0x6.
  - BADV 0x7.
  - EENTRY 0xC: VA[31:6].
  - SAVE0-3 0x30-0x33.
  - TID 0x40.
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42: read-only.
  - TICLR 0x44: write-1-to-clear at bit 0, always reads 0.
  - Any other number reads 0; writes to it are ignored.
- Reset values:
  - CRMD = 32'h8 (DA=1, PLV=0, IE=0).
  - TID = TID_INIT.
  - TVAL = 32'hFFFF_FFFF.
  - All other CSRs = 0.
  - Outputs follow from these: has_int=0, ex_entry=0, ertn_entry=0.
- Masked write: new = (old & ~mask) | (val & mask), applied to writable fields only.
  - ESTAT: only IS[1:0] is writable.
  - BADV and TVAL are not software writable.
- All updates take effect on the next edge; a read in the same cycle returns the old value (no bypass).
- Exception (ex_valid=1):
  - PRMD.PPLV <= CRMD.PLV; PRMD.PIE <= CRMD.IE.
  - CRMD.PLV <= 0; CRMD.IE <= 0.
  - ERA <= ex_pc.
  - ESTAT.Ecode <= ex_ecode; ESTAT.EsubCode <= ex_esubcode.
  - BADV <= ex_pc when ecode = ADE (6'h08); BADV <= ex_vaddr when ecode = ALE (6'h09); otherwise BADV unchanged.
- ERTN (ertn_flush=1): CRMD.PLV <= PRMD.PPLV; CRMD.IE <= PRMD.PIE.
- Same-cycle priority on CRMD/PRMD/ERA/ESTAT fields: ex_valid > ertn_flush > csr_we.
  - csr_we with ex_valid is a pipeline violation; the write is dropped.
- ESTAT.IS inputs:
  - IS[9:2] sampled from hw_int_in every cycle.
  - IS[12] sampled from ipi_int_in every cycle.
  - IS[11] is the timer interrupt: set by a timer event, cleared by a TICLR write of bit0=1. If both occur in the same cycle, set wins.
- Timer:
  - A TCFG write loads TVAL <= {new InitVal, 2'b00}; the write wins over a decrement in the same cycle.
  - Otherwise, if En=1 and TVAL != 32'hFFFF_FFFF:
    - TVAL==0 with Periodic=1: reload {InitVal, 2'b00}.
    - Any other value: decrement by 1 (one-shot wraps 0 to FFFF_FFFF and stops).
  - A timer event is En=1 and TVAL==0; it sets IS[11] on the next edge.
  - InitVal=0 with Periodic=1 raises an event every cycle.
- has_int = |(ESTAT.IS[12:0] & ECFG.LIE[12:0]) & CRMD.IE. Combinational from registers, so there is a 1-cycle latency from an input line to has_int.
- Reset asserted mid-operation overrides every pending event, including the timer and ex_valid.

Optional Feature:
- Macro: CSR_TIMER_EN.
- Defined: TCFG, TVAL and TICLR are implemented as described in Behaviour.
- Undefined:
  - Addresses 0x41, 0x42 and 0x44 read 0; writes to them are ignored.
  - IS[11] is constant 0.
  - No counter logic is synthesised.

Decomposition:
- Shared defs.v holds:
  - CSR number constants (CSR_CRMD ... CSR_TICLR).
  - Field bit-position constants.
  - The existing ECODE_* constants; ECODE_ADE and ECODE_ALE are the ones used here.
- One sub-module, csr_timer. It contains the TVAL counter and event generation, and is instantiated only under CSR_TIMER_EN.

Test Plan:
- Reset, then read 0x0 -> 32'h8; read 0x5 -> 0; read 0x42 -> FFFF_FFFF; has_int=0.
- Write CRMD PLV=3 IE=1, then ex_valid with ecode=ALE, ex_pc=1C00_0100, ex_vaddr=0000_1003:
  - next cycle: PRMD=32'h7, CRMD.PLV=0, CRMD.IE=0, ERA=1C00_0100, BADV=0000_1003, ESTAT[21:16]=9.
  - Then ertn_flush -> CRMD[2:0]=3'b111.
- TCFG write 32'h0000_0009 (En=1, one-shot, InitVal=2, TVAL=8):
  - IS[11]=1 nine cycles after the write edge; TVAL then holds FFFF_FFFF.
  - TICLR write 1 -> IS[11]=0.
- TCFG periodic with InitVal=1 and LIE[11]=1, CRMD.IE=1:
  - has_int pulses and TVAL reloads 4 every 5 cycles.
  - A TICLR write in the event cycle leaves IS[11]=1.
- Same cycle ex_valid, ertn_flush and csr_we to CRMD val 0 -> exception update only.
- Masked write to ESTAT with mask FFFF_FFFF, val FFFF_FFFF -> only IS[1:0] become 1; ecode/subcode fields unchanged.
